// File: rtl/mem_arbiter.sv
// Single-ported memory bus arbiter between instruction fetch and load/store.
// MEM has priority; after two MEM wins over a waiting fetch, IF gets the bus.
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  input  logic [1:0]  MEM_req_cmd,
  input  logic [31:0] MEM_req_addr,
  input  logic [31:0] MEM_req_din,
  input  logic [31:0] BUS_dout,
  output logic [1:0]  BUS_cmd,
  output logic [31:0] BUS_addr,
  output logic [31:0] BUS_din,
  output logic        ARB_if_rdy,
  output logic [31:0] ARB_if_inst,
  output logic        ARB_mem_rdy,
  output logic [31:0] ARB_mem_dout,
  output logic        ARB_busy
);

  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;
  localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner_mem;
  logic [1:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_din;
  logic [31:0] r_resp;
  logic [3:0]  r_cnt;
  logic [1:0]  r_if_wait;

  logic        w_mem_pend;
  logic        w_grant_if;
  logic        w_grant_mem;

  // Command 11 is not a request, so it can never win the bus.
  assign w_mem_pend  = (MEM_req_cmd == BUS_LOAD) || (MEM_req_cmd == BUS_STORE);
  assign w_grant_if  = IF_req && (!w_mem_pend || (r_if_wait == 2'd2));
  assign w_grant_mem = w_mem_pend && !w_grant_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_if || w_grant_mem) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner_mem <= 1'b0;
      r_cmd       <= BUS_NONE;
      r_addr      <= '0;
      r_din       <= '0;
      r_resp      <= '0;
      r_cnt       <= '0;
      r_if_wait   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_if) begin
            r_owner_mem <= 1'b0;
            r_cmd       <= BUS_LOAD;
            r_addr      <= IF_addr;
            r_din       <= '0;
            r_cnt       <= CNT_INIT;
            r_if_wait   <= '0;
          end else if (w_grant_mem) begin
            r_owner_mem <= 1'b1;
            r_cmd       <= MEM_req_cmd;
            r_addr      <= MEM_req_addr;
            r_din       <= (MEM_req_cmd == BUS_STORE) ? MEM_req_din : '0;
            r_cnt       <= CNT_INIT;
            r_if_wait   <= IF_req ? (r_if_wait + 2'd1) : 2'd0;
          end
        end
        S_ACCESS: begin
          // Read data is only valid in the final access cycle.
          if (r_cnt == 4'd0) r_resp <= (r_cmd == BUS_LOAD) ? BUS_dout : '0;
          else               r_cnt  <= r_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    BUS_cmd      = BUS_NONE;
    BUS_addr     = '0;
    BUS_din      = '0;
    ARB_if_rdy   = 1'b0;
    ARB_if_inst  = '0;
    ARB_mem_rdy  = 1'b0;
    ARB_mem_dout = '0;
    ARB_busy     = (r_state != S_IDLE);
    if (r_state == S_ACCESS) begin
      BUS_cmd  = r_cmd;
      BUS_addr = r_addr;
      BUS_din  = r_din;
    end
    if (r_state == S_RESP) begin
      if (r_owner_mem) begin
        ARB_mem_rdy  = 1'b1;
        ARB_mem_dout = r_resp;
      end else begin
        ARB_if_rdy  = 1'b1;
        ARB_if_inst = r_resp;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 1, 2, 4) driven by queued requesters
// and checked cycle by cycle against a transaction-schedule model.
module tb_mem_arbiter;

  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] STORE = 2'b10;
  localparam logic [1:0] ILL   = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        IF_req_a   [3];
  logic [31:0] IF_addr_a  [3];
  logic [1:0]  MEM_cmd_a  [3];
  logic [31:0] MEM_addr_a [3];
  logic [31:0] MEM_din_a  [3];
  logic [31:0] BUS_dout_a [3];
  logic [1:0]  BUS_cmd_a  [3];
  logic [31:0] BUS_addr_a [3];
  logic [31:0] BUS_din_a  [3];
  logic        if_rdy_a   [3];
  logic [31:0] if_inst_a  [3];
  logic        mem_rdy_a  [3];
  logic [31:0] mem_dout_a [3];
  logic        busy_a     [3];

  mem_arbiter #(.LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .IF_req(IF_req_a[0]), .IF_addr(IF_addr_a[0]),
    .MEM_req_cmd(MEM_cmd_a[0]), .MEM_req_addr(MEM_addr_a[0]), .MEM_req_din(MEM_din_a[0]),
    .BUS_dout(BUS_dout_a[0]), .BUS_cmd(BUS_cmd_a[0]), .BUS_addr(BUS_addr_a[0]),
    .BUS_din(BUS_din_a[0]), .ARB_if_rdy(if_rdy_a[0]), .ARB_if_inst(if_inst_a[0]),
    .ARB_mem_rdy(mem_rdy_a[0]), .ARB_mem_dout(mem_dout_a[0]), .ARB_busy(busy_a[0]));

  mem_arbiter #(.LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .IF_req(IF_req_a[1]), .IF_addr(IF_addr_a[1]),
    .MEM_req_cmd(MEM_cmd_a[1]), .MEM_req_addr(MEM_addr_a[1]), .MEM_req_din(MEM_din_a[1]),
    .BUS_dout(BUS_dout_a[1]), .BUS_cmd(BUS_cmd_a[1]), .BUS_addr(BUS_addr_a[1]),
    .BUS_din(BUS_din_a[1]), .ARB_if_rdy(if_rdy_a[1]), .ARB_if_inst(if_inst_a[1]),
    .ARB_mem_rdy(mem_rdy_a[1]), .ARB_mem_dout(mem_dout_a[1]), .ARB_busy(busy_a[1]));

  mem_arbiter #(.LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .IF_req(IF_req_a[2]), .IF_addr(IF_addr_a[2]),
    .MEM_req_cmd(MEM_cmd_a[2]), .MEM_req_addr(MEM_addr_a[2]), .MEM_req_din(MEM_din_a[2]),
    .BUS_dout(BUS_dout_a[2]), .BUS_cmd(BUS_cmd_a[2]), .BUS_addr(BUS_addr_a[2]),
    .BUS_din(BUS_din_a[2]), .ARB_if_rdy(if_rdy_a[2]), .ARB_if_inst(if_inst_a[2]),
    .ARB_mem_rdy(mem_rdy_a[2]), .ARB_mem_dout(mem_dout_a[2]), .ARB_busy(busy_a[2]));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] din;
  } mop_t;

  logic [31:0] ifq[$];
  mop_t        memq[$];
  bit          if_pres, mem_pres, rand_gaps, mem_noise, dout_fixed_en;
  logic [31:0] dout_fixed;
  int          cyc;

  // Model: one transaction granted at cycle m_g owns cycles m_g+1 .. m_g+LAT+1.
  bit          m_act, m_own_mem;
  logic [1:0]  m_cmd;
  logic [31:0] m_addr, m_din, m_resp;
  int          m_g, m_free, m_wait;

  int          if_rdy_cyc[$], mem_rdy_cyc[$], cmd11_seen;
  logic [31:0] if_data[$], mem_data[$];
  bit          grant_log[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic logic [132:0] obs(input int d);
    return {BUS_cmd_a[d], BUS_addr_a[d], BUS_din_a[d], if_rdy_a[d], if_inst_a[d],
            mem_rdy_a[d], mem_dout_a[d], busy_a[d]};
  endfunction

  task automatic drive_idle();
    for (int d = 0; d < 3; d++) begin
      IF_req_a[d] = 1'b0;  IF_addr_a[d] = '0;  MEM_cmd_a[d] = NONE;
      MEM_addr_a[d] = '0;  MEM_din_a[d] = '0;  BUS_dout_a[d] = '0;
    end
  endtask

  task automatic clear_bench();
    ifq.delete(); memq.delete(); if_rdy_cyc.delete(); mem_rdy_cyc.delete();
    if_data.delete(); mem_data.delete(); grant_log.delete();
    if_pres = 0; mem_pres = 0; rand_gaps = 0; mem_noise = 0; dout_fixed_en = 0;
    dout_fixed = '0; cyc = 0; cmd11_seen = 0;
    m_act = 0; m_own_mem = 0; m_cmd = NONE; m_addr = '0; m_din = '0; m_resp = '0;
    m_g = 0; m_free = 0; m_wait = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    clear_bench();
  endtask

  // One bus cycle on instance d: drive requesters, advance the model, sample at negedge.
  task automatic step(input int d, output logic [132:0] o, output logic [132:0] e);
    int lat = lat_of(d);
    logic [31:0] dout, einst, emdout, eaddr, edin;
    logic [1:0]  ecmd;
    logic        eifr, ememr, ebusy;
    bit          ifp, memp;
    if (!if_pres && ifq.size() > 0 && (!rand_gaps || $urandom_range(1, 0) == 1)) if_pres = 1;
    if (!mem_pres && memq.size() > 0 && (!rand_gaps || $urandom_range(1, 0) == 1)) mem_pres = 1;
    IF_req_a[d]  = if_pres;
    IF_addr_a[d] = if_pres ? ifq[0] : $urandom;
    if (mem_pres) begin
      MEM_cmd_a[d] = memq[0].cmd; MEM_addr_a[d] = memq[0].addr; MEM_din_a[d] = memq[0].din;
    end else begin
      MEM_cmd_a[d]  = (mem_noise || $urandom_range(3, 0) == 0) ? ILL : NONE;
      MEM_addr_a[d] = $urandom; MEM_din_a[d] = $urandom;
    end
    dout = dout_fixed_en ? dout_fixed : $urandom;
    BUS_dout_a[d] = dout;
    ecmd = NONE; eaddr = '0; edin = '0; eifr = 0; einst = '0; ememr = 0; emdout = '0; ebusy = 0;
    if (m_act && cyc > m_g && cyc <= m_g + lat) begin
      ecmd = m_cmd; eaddr = m_addr; edin = m_din; ebusy = 1;
      if (cyc == m_g + lat) m_resp = (m_cmd == LOAD) ? dout : 32'd0;
    end else if (m_act && cyc == m_g + lat + 1) begin
      ebusy = 1;
      if (m_own_mem) begin ememr = 1; emdout = m_resp; end
      else begin eifr = 1; einst = m_resp; end
    end
    if (cyc >= m_free) begin
      ifp = if_pres; memp = mem_pres;
      if (ifp && (!memp || m_wait == 2)) begin
        m_act = 1; m_own_mem = 0; m_cmd = LOAD; m_addr = ifq[0]; m_din = '0;
        m_wait = 0; m_g = cyc; m_free = cyc + lat + 2;
      end else if (memp) begin
        m_act = 1; m_own_mem = 1; m_cmd = memq[0].cmd; m_addr = memq[0].addr;
        m_din = (memq[0].cmd == STORE) ? memq[0].din : 32'd0;
        m_wait = ifp ? m_wait + 1 : 0; m_g = cyc; m_free = cyc + lat + 2;
      end
    end
    e = {ecmd, eaddr, edin, eifr, einst, ememr, emdout, ebusy};
    @(negedge clk);
    o = obs(d);
    if (if_rdy_a[d]) begin if_rdy_cyc.push_back(cyc); if_data.push_back(if_inst_a[d]); grant_log.push_back(1'b0); end
    if (mem_rdy_a[d]) begin mem_rdy_cyc.push_back(cyc); mem_data.push_back(mem_dout_a[d]); grant_log.push_back(1'b1); end
    if (BUS_cmd_a[d] == ILL) cmd11_seen++;
    if (eifr) begin void'(ifq.pop_front()); if_pres = 0; end
    if (ememr) begin void'(memq.pop_front()); mem_pres = 0; end
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (obs(d) !== 133'd0) begin
        errors++;
        $display("FAIL reset_outputs lat=%0d got %h exp 0", lat_of(d), obs(d));
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    clear_bench();
  endtask

  task automatic test_single_fetch();
    logic [132:0] o, e;
    apply_reset();
    dout_fixed_en = 1; dout_fixed = 32'hDEADBEEF;
    ifq.push_back(32'h100);
    for (int i = 0; i < 6; i++) begin
      step(1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL single_fetch cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (if_rdy_cyc.size() != 1 || if_rdy_cyc[0] != 3 || if_data[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_fetch_rdy n=%0d cyc=%0d data=%h exp n=1 cyc=3 data=deadbeef",
               if_rdy_cyc.size(), if_rdy_cyc[0], if_data[0]);
    end
  endtask

  task automatic test_store();
    logic [132:0] o, e;
    apply_reset();
    memq.push_back('{STORE, 32'h2000, 32'h55});
    for (int i = 0; i < 6; i++) begin
      step(1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL store cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (mem_rdy_cyc.size() != 1 || mem_rdy_cyc[0] != 3 || mem_data[0] !== 32'd0) begin
      errors++;
      $display("FAIL store_rdy n=%0d cyc=%0d data=%h exp n=1 cyc=3 data=0",
               mem_rdy_cyc.size(), mem_rdy_cyc[0], mem_data[0]);
    end
  endtask

  task automatic test_contention();
    logic [132:0] o, e;
    apply_reset();
    ifq.push_back(32'h40);
    memq.push_back('{LOAD, 32'h3000, 32'h0});
    for (int i = 0; i < 10; i++) begin
      step(1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL contention cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (mem_rdy_cyc.size() != 1 || mem_rdy_cyc[0] != 3 || if_rdy_cyc.size() != 1 || if_rdy_cyc[0] != 7) begin
      errors++;
      $display("FAIL contention_order mem_rdy=%0d if_rdy=%0d exp mem_rdy=3 if_rdy=7",
               mem_rdy_cyc[0], if_rdy_cyc[0]);
    end
  endtask

  task automatic test_anti_starvation();
    logic [132:0] o, e;
    bit exp_log[9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) ifq.push_back(32'h1000 + 32'(4 * i));
    for (int i = 0; i < 6; i++) memq.push_back('{LOAD, 32'h8000 + 32'(4 * i), 32'h0});
    for (int i = 0; i < 40; i++) begin
      step(1, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL starvation cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (grant_log.size() != 9) begin
      errors++; $display("FAIL starvation_count got %0d grants exp 9", grant_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (grant_log[i] != exp_log[i]) begin
          errors++;
          $display("FAIL starvation_grant %0d got %s exp %s", i,
                   grant_log[i] ? "MEM" : "IF", exp_log[i] ? "MEM" : "IF");
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [132:0] o, e;
    int rdy_seen = 0;
    apply_reset();
    memq.push_back('{LOAD, 32'h12345670, 32'h0});
    step(2, o, e);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs(2) !== 133'd0) begin errors++; $display("FAIL reset_mid_immediate got %h exp 0", obs(2)); end
    MEM_cmd_a[2] = NONE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_rdy_a[2] || if_rdy_a[2] || busy_a[2]) rdy_seen++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    checks++;
    if (rdy_seen != 0) begin errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", rdy_seen); end
    clear_bench();
    memq.push_back('{LOAD, 32'hA0A0A0A0, 32'h0});
    for (int i = 0; i < 8; i++) begin
      step(2, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid_after cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (mem_rdy_cyc.size() != 1 || mem_rdy_cyc[0] != 5) begin
      errors++;
      $display("FAIL reset_mid_fresh n=%0d cyc=%0d exp n=1 cyc=5", mem_rdy_cyc.size(), mem_rdy_cyc[0]);
    end
  endtask

  task automatic test_lat1_back_to_back();
    logic [132:0] o, e;
    apply_reset();
    mem_noise = 1;
    ifq.push_back(32'h0);
    ifq.push_back(32'h4);
    for (int i = 0; i < 8; i++) begin
      step(0, o, e);
      checks++;
      if (o !== e) begin errors++; $display("FAIL lat1 cyc %0d got %h exp %h", cyc - 1, o, e); end
    end
    checks++;
    if (if_rdy_cyc.size() != 2 || if_rdy_cyc[0] != 2 || if_rdy_cyc[1] != 5 ||
        mem_rdy_cyc.size() != 0 || cmd11_seen != 0) begin
      errors++;
      $display("FAIL lat1_timing if_n=%0d c0=%0d c1=%0d mem_n=%0d cmd11=%0d exp 2,2,5,0,0",
               if_rdy_cyc.size(), if_rdy_cyc[0], if_rdy_cyc[1], mem_rdy_cyc.size(), cmd11_seen);
    end
  endtask

  task automatic test_random();
    logic [132:0] o, e;
    for (int d = 0; d < 3; d++) begin
      apply_reset();
      rand_gaps = 1;
      for (int i = 0; i < 12; i++) begin
        ifq.push_back($urandom);
        memq.push_back('{($urandom_range(1, 0) == 1) ? STORE : LOAD, $urandom, $urandom});
      end
      for (int i = 0; i < 250; i++) begin
        step(d, o, e);
        checks++;
        if (o !== e) begin errors++; $display("FAIL random lat=%0d cyc %0d got %h exp %h", lat_of(d), cyc - 1, o, e); end
      end
      checks++;
      if (ifq.size() != 0 || memq.size() != 0 || cmd11_seen != 0) begin
        errors++;
        $display("FAIL random_drain lat=%0d ifq=%0d memq=%0d cmd11=%0d exp 0,0,0",
                 lat_of(d), ifq.size(), memq.size(), cmd11_seen);
      end
    end
  endtask

  initial begin
    clear_bench();
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_anti_starvation();
    test_reset_mid_access();
    test_lat1_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline. Each requester holds a request until it receives a one-cycle ready pulse with response data. Ready pulses drive the pipeline-register enables, and `ARB_busy` feeds the stalling module. The block owns the bus sequencing through a fixed-latency access state machine.

## Interface
- `LAT`, default 2: memory access cycles per transaction; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-low.
- `IF_req`  input  1  fetch request; held until `ARB_if_rdy`.
- `IF_addr`  input  32  fetch address.
- `MEM_req_cmd`  input  2  `BUS_NONE` (00), `BUS_LOAD` (01), `BUS_STORE` (10); 11 is ignored (treated as NONE).
- `MEM_req_addr`  input  32  data address.
- `MEM_req_din`  input  32  store data.
- `BUS_dout`  input  32  memory read data; valid in the last access cycle.
- `BUS_cmd`  output  2  bus command; never 11.
- `BUS_addr`  output  32  bus address.
- `BUS_din`  output  32  bus write data.
- `ARB_if_rdy`  output  1  one-cycle pulse: fetch complete.
- `ARB_if_inst`  output  32  fetched word; valid with `ARB_if_rdy`.
- `ARB_mem_rdy`  output  1  one-cycle pulse: data access complete.
- `ARB_mem_dout`  output  32  load data; valid with `ARB_mem_rdy`; 0 for stores.
- `ARB_busy`  output  1  high in any state other than IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - Samples requests. A MEM request is pending when `MEM_req_cmd` is LOAD or STORE.
  - If nothing is pending, stay in IDLE.
  - If a requester is pending, grant it: latch owner, cmd, addr and din into internal registers, load the access counter with `LAT`-1, and go to ACCESS.
- **Priority:** MEM beats IF. The exception is the anti-starvation rule below.
- **Anti-starvation:**
  - A 2-bit counter `if_wait` increments each time MEM wins while `IF_req` is high.
  - The counter clears when IF is granted, or when MEM wins while `IF_req` is low.
  - When `if_wait`==2 and both are pending, IF wins.
- **ACCESS:**
  - `BUS_cmd`/`BUS_addr`/`BUS_din` are driven from the latched registers. Fetch is LOAD; `BUS_din` is 0 for loads.
  - The counter decrements each cycle.
  - When the counter is 0 (last access cycle), capture `BUS_dout` for loads (0 for stores) into the response register and go to RESP.
- **RESP:**
  - Bus outputs return to `BUS_NONE`/0/0.
  - Pulse the owner's rdy, with the response register on the owner's data output.
  - Next state is IDLE unconditionally.
- **Requester contract:** the requester updates or drops its request on the clock edge at the end of the rdy cycle. IDLE therefore never re-serves a completed request.
- **Request changes:** request inputs are only sampled in IDLE. Changes during ACCESS/RESP are ignored.
- **Idle data outputs:** `ARB_if_inst` and `ARB_mem_dout` are 0 whenever their rdy is low.
- **Reset (asserted at any time, including mid-ACCESS):**
  - State goes to IDLE; `if_wait`, the counter and the latched registers clear.
  - No rdy pulse is produced for the aborted transaction.

## Timing
- **Reset values:** `BUS_cmd`=`BUS_NONE`, `BUS_addr`=0, `BUS_din`=0, `ARB_if_rdy`=0, `ARB_mem_rdy`=0, `ARB_if_inst`=0, `ARB_mem_dout`=0, `ARB_busy`=0.
- **Outputs:** all outputs are registered (state-decoded from registered state); no combinational input-to-output paths.
- **Transaction latency:** request high in IDLE at cycle t → ACCESS cycles t+1..t+`LAT` → rdy pulse at t+`LAT`+1 → IDLE at t+`LAT`+2. Issue interval is `LAT`+2 cycles.
- **`ARB_busy`:** high from t+1 through t+`LAT`+1.
- **Simultaneous requests, `LAT`=2, request at cycle 0:** MEM rdy at cycle 3, IDLE at 4, IF ACCESS at 5..6, IF rdy at 7.
- **`LAT`=1:** a single ACCESS cycle; the counter is loaded with 0.

## Test plan
- **Single fetch:**
  - Stimulus: `LAT`=2, `IF_req`=1, `IF_addr`=0x100 at cycle 0, `BUS_dout`=0xDEADBEEF at cycle 2.
  - Response: `BUS_cmd`=LOAD, addr 0x100 in cycles 1–2; `ARB_if_rdy`=1 with `ARB_if_inst`=0xDEADBEEF at cycle 3 only; `ARB_busy` high in cycles 1–3.
- **Store:**
  - Stimulus: `MEM_req_cmd`=STORE, addr 0x2000, din 0x55.
  - Response: `BUS_cmd`=STORE, `BUS_addr`=0x2000, `BUS_din`=0x55 in cycles 1–2; `ARB_mem_rdy` at cycle 3 with `ARB_mem_dout`=0.
- **Contention:**
  - Stimulus: IF fetch 0x40 and MEM load 0x3000 both at cycle 0, `LAT`=2.
  - Response: load bus cycles 1–2, `ARB_mem_rdy` at 3; fetch bus cycles 5–6, `ARB_if_rdy` at 7.
- **Anti-starvation:**
  - Stimulus: `IF_req` held high; MEM issues a new load each time it receives rdy.
  - Response: grants are MEM, MEM, IF, MEM, MEM, IF…
- **Reset mid-access:**
  - Stimulus: `rst` low during cycle 1 of a `LAT`=4 load.
  - Response: all outputs zero immediately; no rdy ever; a fresh request after release completes normally.
- **`LAT`=1 back-to-back fetches:**
  - Stimulus: consecutive fetches to 0x0 and 0x4.
  - Response: one ACCESS cycle each; rdy pulses 3 cycles apart; `BUS_cmd` never 11; an illegal `MEM_req_cmd`=11 never wins a grant.
